// File: rtl/lane_serializer.sv
// lane_serializer: captures a NUM_IN-lane vector and emits one lane (FIXED) or lanes 0..sel_last (SWEEP) as valid/ready beats
module lane_serializer #(
  parameter int NUM_IN = 8,
  parameter int DATA_W = 1,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel_cfg,
  input  logic [SEL_W-1:0]         sel_last,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready
);
  typedef enum logic {IDLE, EMIT} state_t;
  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_IN - 1);
  state_t state, state_nx;
  logic [NUM_IN*DATA_W-1:0] hold_data;
  logic hold_mode;
  logic [SEL_W-1:0] hold_last, sel_nx, cfg_c, last_c;
  logic in_hs, out_hs;
  assign cfg_c = sel_cfg > MAX_SEL ? MAX_SEL : sel_cfg;
  assign last_c = sel_last > MAX_SEL ? MAX_SEL : sel_last;
  assign out_valid = state == EMIT;
  assign out_last = out_valid & (~hold_mode | (out_sel == hold_last));
  assign out_data = hold_data[out_sel*DATA_W +: DATA_W];
  assign out_hs = out_valid & out_ready;
  assign in_ready = aresetn & ((state == IDLE) | (out_hs & out_last));
  assign in_hs = in_valid & in_ready;
  always_comb begin
    state_nx = state;
    sel_nx = out_sel;
    if (in_hs) begin
      state_nx = EMIT;
      sel_nx = mode ? '0 : cfg_c;
    end else if (out_hs) begin
      state_nx = out_last ? IDLE : EMIT;
      sel_nx = out_last ? out_sel : out_sel + 1'b1;
    end
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      out_sel <= '0;
      hold_data <= '0;
      hold_mode <= 1'b0;
      hold_last <= '0;
    end else begin
      state <= state_nx;
      out_sel <= sel_nx;
      if (in_hs) begin
        hold_data <= in_data;
        hold_mode <= mode;
        hold_last <= last_c;
      end
    end
  end
endmodule

// File: tb/tb_lane_serializer.sv
// tb_lane_serializer: directed checks of lane_serializer against a beat-queue model
module tb_lane_serializer;
  typedef struct packed {logic [7:0] d; logic [3:0] s; logic l;} beat_t;
  logic clk = 0;
  always #5 clk = ~clk;
  logic aresetn = 1, in_valid = 0, mode = 0, out_ready = 0, cur = 0;
  logic [31:0] vec = 0;
  logic [3:0] sel_cfg = 0, sel_last = 0;
  logic ir_a, ov_a, ol_a, da, ir_b, ov_b, ol_b;
  logic [3:0] sa;
  logic [7:0] db;
  logic [1:0] sb;
  logic i_ready, o_valid, o_last;
  logic [7:0] o_data;
  logic [3:0] o_sel;
  int total = 0, bad = 0, hs_cnt = 0, pops = 0;
  beat_t q[$];
  lane_serializer #(.NUM_IN(8), .DATA_W(1), .SEL_W(4)) dut_a (
    .aclk(clk), .aresetn(aresetn), .in_data(vec[7:0]), .in_valid(in_valid & ~cur), .in_ready(ir_a),
    .mode(mode), .sel_cfg(sel_cfg), .sel_last(sel_last), .out_data(da), .out_sel(sa),
    .out_last(ol_a), .out_valid(ov_a), .out_ready(out_ready & ~cur));
  lane_serializer #(.NUM_IN(4), .DATA_W(8)) dut_b (
    .aclk(clk), .aresetn(aresetn), .in_data(vec), .in_valid(in_valid & cur), .in_ready(ir_b),
    .mode(mode), .sel_cfg(sel_cfg[1:0]), .sel_last(sel_last[1:0]), .out_data(db), .out_sel(sb),
    .out_last(ol_b), .out_valid(ov_b), .out_ready(out_ready & cur));
  assign i_ready = cur ? ir_b : ir_a;
  assign o_valid = cur ? ov_b : ov_a;
  assign o_last = cur ? ol_b : ol_a;
  assign o_data = cur ? db : {7'd0, da};
  assign o_sel = cur ? {2'd0, sb} : sa;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic void push();
    int ni = cur ? 4 : 8;
    int dw = cur ? 8 : 1;
    int c = cur ? int'(sel_cfg[1:0]) : int'(sel_cfg);
    int l = cur ? int'(sel_last[1:0]) : int'(sel_last);
    c = c > ni - 1 ? ni - 1 : c;
    l = l > ni - 1 ? ni - 1 : l;
    if (!mode) q.push_back('{8'((vec >> (c*dw)) & ((32'd1 << dw) - 1)), 4'(c), 1'b1});
    else for (int k = 0; k <= l; k++) q.push_back('{8'((vec >> (k*dw)) & ((32'd1 << dw) - 1)), 4'(k), k == l});
  endfunction
  always @(posedge clk) begin
    if (!aresetn) begin
      chk("rst_valid", o_valid, 0);
      chk("rst_last", o_last, 0);
      chk("rst_sel", o_sel, 0);
      chk("rst_data", o_data, 0);
      chk("rst_in_ready", i_ready, 0);
      q.delete();
    end else begin
      chk("in_ready", i_ready, q.size() == 0 || (out_ready && q.size() == 1));
      chk("out_valid", o_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("out_data", o_data, q[0].d);
        chk("out_sel", o_sel, q[0].s);
        chk("out_last", o_last, q[0].l);
        if (out_ready) begin
          void'(q.pop_front());
          pops++;
        end
      end
      if (in_valid && i_ready) begin
        push();
        hs_cnt++;
      end
    end
  end
  task automatic send(input logic [31:0] v, input logic m, input logic [3:0] c, input logic [3:0] l);
    int n0;
    @(negedge clk);
    vec = v; mode = m; sel_cfg = c; sel_last = l; in_valid = 1;
    n0 = hs_cnt;
    for (int i = 0; i < 40 && hs_cnt == n0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("hs_timeout", hs_cnt != n0, 1);
  endtask
  task automatic drain();
    in_valid = 0;
    for (int i = 0; i < 100 && (q.size() != 0 || o_valid); i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain", q.size(), 0);
  endtask
  int exp1[8] = '{0, 1, 1, 0, 0, 1, 0, 1};
  int exp2[4] = '{'h11, 'h22, 'h33, 'h44};
  int rdy3[6] = '{1, 0, 0, 1, 1, 1};
  int sel3[6] = '{0, 1, 1, 1, 2, 3};
  int dat3[6] = '{'hAA, 'hBB, 'hBB, 'hBB, 'hCC, 'hDD};
  int p0;
  initial begin
    #2 aresetn = 0;
    #1;
    chk("init_valid", o_valid, 0);
    chk("init_in_ready", i_ready, 0);
    repeat (3) @(negedge clk);
    aresetn = 1;
    #1 chk("ready_after_rst", i_ready, 1);
    out_ready = 1;
    for (int s = 0; s < 8; s++) begin
      send(32'hA6, 0, 4'(s), 0);
      chk("fixed_latency", o_valid, 1);
      chk("fixed_data", o_data, exp1[s]);
      chk("fixed_last", o_last, 1);
      chk("fixed_sel", o_sel, s);
    end
    drain();
    cur = 1;
    send(32'h44332211, 1, 0, 3);
    in_valid = 0;
    for (int k = 0; k < 4; k++) begin
      chk("sweep_data", o_data, exp2[k]);
      chk("sweep_sel", o_sel, k);
      chk("sweep_last", o_last, k == 3);
      chk("sweep_in_ready", i_ready, k == 3);
      @(posedge clk);
      #1;
    end
    chk("sweep_done", o_valid, 0);
    send(32'hDDCCBBAA, 1, 0, 3);
    in_valid = 0;
    for (int i = 0; i < 6; i++) begin
      chk("stall_sel", o_sel, sel3[i]);
      chk("stall_data", o_data, dat3[i]);
      out_ready = rdy3[i][0];
      @(posedge clk);
      #1;
    end
    out_ready = 1;
    chk("stall_done", o_valid, 0);
    drain();
    cur = 0;
    p0 = pops;
    for (int i = 0; i < 16; i++) send(32'(8'(i*37 + 5)), 0, 4'(i % 8), 0);
    drain();
    chk("b2b_beats", pops - p0, 16);
    p0 = pops;
    send(32'hC3, 1, 5, 9);
    in_valid = 0;
    mode = 0; sel_cfg = 2; sel_last = 1;
    drain();
    chk("clamp_beats", pops - p0, 8);
    send(32'h80, 0, 12, 0);
    chk("clamp_fixed_sel", o_sel, 7);
    chk("clamp_fixed_data", o_data, 1);
    drain();
    send(32'hF0, 1, 0, 3);
    in_valid = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_sel", o_sel, 2);
    @(negedge clk);
    aresetn = 0;
    #1;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_last", o_last, 0);
    chk("mid_rst_sel", o_sel, 0);
    chk("mid_rst_data", o_data, 0);
    chk("mid_rst_in_ready", i_ready, 0);
    repeat (2) @(negedge clk);
    aresetn = 1;
    #1 chk("post_rst_in_ready", i_ready, 1);
    @(posedge clk);
    #1 chk("post_rst_valid", o_valid, 0);
    p0 = pops;
    send(32'h02, 1, 0, 1);
    in_valid = 0;
    chk("fresh_sel0", o_sel, 0);
    chk("fresh_data0", o_data, 0);
    @(posedge clk);
    #1;
    chk("fresh_sel1", o_sel, 1);
    chk("fresh_data1", o_data, 1);
    chk("fresh_last1", o_last, 1);
    drain();
    chk("fresh_beats", pops - p0, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #400000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
